// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving an external 1-bit
// full-adder cell, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub port for a - b).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   res_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   res_nxt;
  logic               last_bit;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // Operand B / carry-in as loaded on an accepted start
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // Result after this cycle's bit enters at the MSB; final bit when cnt hits WIDTH-1
  assign res_nxt  = {fa_sum, res_sr};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Bit-cell drive: only from registers, forced low outside RUN
  assign fa_a = (state == RUN) & a_sr[0];
  assign fa_b = (state == RUN) & b_sr[0];
  assign fa_c = (state == RUN) & carry;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Registered status flags, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  // Operand shift registers, carry flop, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_sr <= res_nxt[WIDTH-1:1];
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= fa_carry;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a behavioural full-adder cell.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin_i, sub_i;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, cout, fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  always #5 clk = ~clk;

  // Behavioural full-adder cell
  assign {fa_carry, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_c);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_i),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operand values
  function automatic logic [W:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic ci, input logic s);
    int r;
    if (s) begin
      r = int'(av) - int'(bv);
      return {(av >= bv), W'(r)};
    end
    r = int'(av) + int'(bv) + int'(ci);
    return (W+1)'(r);
  endfunction

  // One full operation with cycle-accurate checks; optional start re-pulse cycle
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic s, input int repulse);
    int ndone;
    logic [W:0] r;
    r = ref_op(av, bv, ci, s);
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    a_i = av; b_i = bv; cin_i = ci; sub_i = s; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= int'(W) + 2; cyc++) begin
      if (cyc == 1) check("fa_c_first", 64'(fa_c), 64'(s ? 1'b1 : ci));
      if (cyc <= int'(W)) check("busy_run", 64'(busy), 64'd1);
      if (cyc == int'(W) + 1) begin
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("sum", 64'(sum), 64'(exp_sum));
        check("cout", 64'(cout), 64'(exp_cout));
        check("fa_done", 64'({fa_a, fa_b, fa_c}), 64'd0);
      end
      if (cyc == int'(W) + 2) begin
        check("done_clear", 64'(done), 64'd0);
        check("fa_idle", 64'({fa_a, fa_b, fa_c}), 64'd0);
      end
      if (done) ndone++;
      if (cyc == repulse) begin
        start = 1'b1; a_i = 8'h01; b_i = 8'h01;
      end else begin
        start = 1'b0;
        if (cyc == 2 && repulse < 0) begin
          a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
        end
      end
      tick();
    end
    check("done_count", 64'(ndone), 64'd1);
  endtask

  initial begin
    int found, ndone;
    logic [W:0] r;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
    rst = 1'b0;
    tick();

    // Directed additions
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, -1);
    check("basic_sum_const", 64'(sum), 64'h8D);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    check("chain1_const", 64'({cout, sum}), 64'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
    check("chain2_const", 64'({cout, sum}), 64'h1FF);

    // Start re-pulsed mid-run is ignored
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 4);

    // Start held continuously: second acceptance at edge W+2
    a_i = 8'h03; b_i = 8'h04; cin_i = 1'b0; sub_i = 1'b0; start = 1'b1;
    tick();
    found = -1;
    for (int cyc = 1; cyc <= int'(W) + 6; cyc++) begin
      if (cyc == int'(W) + 1) check("held_first_sum", 64'(sum), 64'h07);
      if (cyc == int'(W) + 1) begin a_i = 8'h20; b_i = 8'h11; end
      if (cyc > int'(W) + 1 && busy && found < 0) found = cyc;
      tick();
    end
    check("held_accept_cyc", 64'(found - 1), 64'(W + 2));
    start = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < int'(W) + 4 && ndone == 0; cyc++) begin
      if (done) begin
        ndone++;
        check("held_second_sum", 64'({cout, sum}), 64'h031);
      end
      tick();
    end
    check("held_second_done", 64'(ndone), 64'd1);
    tick();

    // Reset mid-operation
    a_i = 8'h5A; b_i = 8'h33; cin_i = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 5; cyc++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'({cout, sum}), 64'd0);
    ndone = 0;
    for (int cyc = 0; cyc < int'(W) + 4; cyc++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, -1);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, -1);
    check("sub1_const", 64'({cout, sum}), 64'h10F);
    do_op(8'h10, 8'h01, 1'b1, 1'b1, -1);
    check("sub1_cin", 64'({cout, sum}), 64'h10F);
    do_op(8'h00, 8'h01, 1'b0, 1'b1, -1);
    check("sub2_const", 64'({cout, sum}), 64'h0FF);
    do_op(8'h00, 8'h01, 1'b1, 1'b1, -1);
    check("sub2_cin", 64'({cout, sum}), 64'h0FF);
`endif

    // Random operations
    for (int i = 0; i < 16; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1);
`else
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, -1);
`endif
      if (i % 4 == 3) begin
        // Results hold and the cell stays undriven while operands toggle in IDLE
        for (int k = 0; k < 4; k++) begin
          a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
          tick();
          check("idle_hold", 64'({cout, sum}), 64'({exp_cout, exp_sum}));
          check("idle_fa", 64'({fa_a, fa_b, fa_c, busy, done}), 64'd0);
        end
      end
    end

    r = ref_op(8'h5A, 8'h33, 1'b0, 1'b0);
    check("model_sanity_in_use", 64'(r), 64'h08D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
